// File: rtl/cl_axi_slice_pkg.sv
// Shared constants and payload types for the AXI register slice.
package cl_axi_slice_pkg;

  localparam int SLICE_BYPASS = 0;
  localparam int SLICE_REG    = 1;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;
  localparam int LEN_W  = 8;
  localparam int SIZE_W = 3;
  localparam int RESP_W = 2;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    SLICE_EMPTY = 2'd0,
    SLICE_ONE   = 2'd1,
    SLICE_FULL  = 2'd2
  } slice_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [ID_W-1:0]   id;
    logic [LEN_W-1:0]  len;
    logic [SIZE_W-1:0] size;
  } aw_payload_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic              last;
  } w_payload_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [RESP_W-1:0] resp;
  } b_payload_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [ID_W-1:0]   id;
    logic [LEN_W-1:0]  len;
    logic [SIZE_W-1:0] size;
  } ar_payload_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [RESP_W-1:0] resp;
    logic              last;
  } r_payload_t;

endpackage

// File: rtl/axi_bus_t.sv
// AXI bus bundle; 'master' is the view of a port facing an AXI master, 'slave' faces an AXI slave.
interface axi_bus_t;
  import cl_axi_slice_pkg::*;

  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [ID_W-1:0]   awid;
  logic [LEN_W-1:0]  awlen;
  logic [SIZE_W-1:0] awsize;

  logic              wvalid;
  logic              wready;
  logic [ID_W-1:0]   wid;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;

  logic              bvalid;
  logic              bready;
  logic [ID_W-1:0]   bid;
  logic [RESP_W-1:0] bresp;

  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [ID_W-1:0]   arid;
  logic [LEN_W-1:0]  arlen;
  logic [SIZE_W-1:0] arsize;

  logic              rvalid;
  logic              rready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [RESP_W-1:0] rresp;
  logic              rlast;

  modport master (
    input  awvalid, awaddr, awid, awlen, awsize, output awready,
    input  wvalid, wid, wdata, wstrb, wlast,     output wready,
    output bvalid, bid, bresp,                   input  bready,
    input  arvalid, araddr, arid, arlen, arsize, output arready,
    output rvalid, rid, rdata, rresp, rlast,     input  rready
  );

  modport slave (
    output awvalid, awaddr, awid, awlen, awsize, input  awready,
    output wvalid, wid, wdata, wstrb, wlast,     input  wready,
    input  bvalid, bid, bresp,                   output bready,
    output arvalid, araddr, arid, arlen, arsize, input  arready,
    input  rvalid, rid, rdata, rresp, rlast,     output rready
  );

endinterface

// File: rtl/cl_axi_skid_slice.sv
// Generic valid/ready channel stage: plain wire (MODE 0) or 2-entry skid slice (MODE 1).
module cl_axi_skid_slice
  import cl_axi_slice_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MODE  = SLICE_REG
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             src_valid_i,
  input  logic [WIDTH-1:0] src_data_i,
  output logic             src_ready_o,
  output logic             dst_valid_o,
  output logic [WIDTH-1:0] dst_data_o,
  input  logic             dst_ready_i,
  output logic             idle_o
);

  if (MODE == SLICE_BYPASS) begin : g_bypass
    assign dst_valid_o = src_valid_i;
    assign dst_data_o  = src_data_i;
    assign src_ready_o = dst_ready_i;
    assign idle_o      = 1'b1;
  end else begin : g_reg
    slice_state_e     state_q, state_d;
    logic             ready_q;
    logic [WIDTH-1:0] main_q, skid_q;
    logic             in_fire, out_fire;
    logic             main_load, main_from_skid, skid_load;

    assign in_fire  = src_valid_i & ready_q;
    assign out_fire = (state_q != SLICE_EMPTY) & dst_ready_i;

    // Next-state and register-load decode
    always_comb begin
      state_d        = state_q;
      main_load      = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      case (state_q)
        SLICE_EMPTY: begin
          if (in_fire) begin
            state_d   = SLICE_ONE;
            main_load = 1'b1;
          end else begin
            state_d = SLICE_EMPTY;
          end
        end
        SLICE_ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            state_d   = SLICE_FULL;
            skid_load = 1'b1;
          end else if (out_fire) begin
            state_d = SLICE_EMPTY;
          end else begin
            state_d = SLICE_ONE;
          end
        end
        SLICE_FULL: begin
          if (out_fire) begin
            state_d        = SLICE_ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end else begin
            state_d = SLICE_FULL;
          end
        end
        default: state_d = SLICE_EMPTY;
      endcase
    end

    // Ready is registered from the next state so it never sees dst_ready combinationally
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q <= SLICE_EMPTY;
        ready_q <= 1'b0;
      end else begin
        state_q <= state_d;
        ready_q <= (state_d != SLICE_FULL);
      end
    end

    // Payload storage; contents are only visible while the state is non-empty
    always_ff @(posedge clk_i) begin
      if (main_load) begin
        main_q <= main_from_skid ? skid_q : src_data_i;
      end
      if (skid_load) begin
        skid_q <= src_data_i;
      end
    end

    assign src_ready_o = ready_q;
    assign dst_valid_o = (state_q != SLICE_EMPTY);
    assign dst_data_o  = main_q;
    assign idle_o      = (state_q == SLICE_EMPTY);
  end

endmodule

// File: rtl/cl_axi_reg_slice.sv
// AXI register slice: one independent skid stage per channel, each selectable as wire or register.
module cl_axi_reg_slice
  import cl_axi_slice_pkg::*;
#(
  parameter int AW_MODE = SLICE_REG,
  parameter int W_MODE  = SLICE_REG,
  parameter int B_MODE  = SLICE_REG,
  parameter int AR_MODE = SLICE_REG,
  parameter int R_MODE  = SLICE_REG
) (
  input  logic      clock,
  input  logic      reset,
  axi_bus_t.master  s_axi_bus,
  axi_bus_t.slave   m_axi_bus,
  output logic      idle
);

  aw_payload_t aw_in_s, aw_out_s;
  w_payload_t  w_in_s,  w_out_s;
  b_payload_t  b_in_s,  b_out_s;
  ar_payload_t ar_in_s, ar_out_s;
  r_payload_t  r_in_s,  r_out_s;
  logic        aw_idle_s, w_idle_s, b_idle_s, ar_idle_s, r_idle_s;

  assign aw_in_s = {s_axi_bus.awaddr, s_axi_bus.awid, s_axi_bus.awlen, s_axi_bus.awsize};
  assign {m_axi_bus.awaddr, m_axi_bus.awid, m_axi_bus.awlen, m_axi_bus.awsize} = aw_out_s;
  assign w_in_s  = {s_axi_bus.wid, s_axi_bus.wdata, s_axi_bus.wstrb, s_axi_bus.wlast};
  assign {m_axi_bus.wid, m_axi_bus.wdata, m_axi_bus.wstrb, m_axi_bus.wlast} = w_out_s;
  assign ar_in_s = {s_axi_bus.araddr, s_axi_bus.arid, s_axi_bus.arlen, s_axi_bus.arsize};
  assign {m_axi_bus.araddr, m_axi_bus.arid, m_axi_bus.arlen, m_axi_bus.arsize} = ar_out_s;
  // Response channels flow from the downstream bus back to the upstream bus
  assign b_in_s  = {m_axi_bus.bid, m_axi_bus.bresp};
  assign {s_axi_bus.bid, s_axi_bus.bresp} = b_out_s;
  assign r_in_s  = {m_axi_bus.rid, m_axi_bus.rdata, m_axi_bus.rresp, m_axi_bus.rlast};
  assign {s_axi_bus.rid, s_axi_bus.rdata, s_axi_bus.rresp, s_axi_bus.rlast} = r_out_s;

  cl_axi_skid_slice #(.WIDTH($bits(aw_payload_t)), .MODE(AW_MODE)) u_aw (
    .clk_i(clock), .rst_i(reset),
    .src_valid_i(s_axi_bus.awvalid), .src_data_i(aw_in_s), .src_ready_o(s_axi_bus.awready),
    .dst_valid_o(m_axi_bus.awvalid), .dst_data_o(aw_out_s), .dst_ready_i(m_axi_bus.awready),
    .idle_o(aw_idle_s)
  );

  cl_axi_skid_slice #(.WIDTH($bits(w_payload_t)), .MODE(W_MODE)) u_w (
    .clk_i(clock), .rst_i(reset),
    .src_valid_i(s_axi_bus.wvalid), .src_data_i(w_in_s), .src_ready_o(s_axi_bus.wready),
    .dst_valid_o(m_axi_bus.wvalid), .dst_data_o(w_out_s), .dst_ready_i(m_axi_bus.wready),
    .idle_o(w_idle_s)
  );

  cl_axi_skid_slice #(.WIDTH($bits(ar_payload_t)), .MODE(AR_MODE)) u_ar (
    .clk_i(clock), .rst_i(reset),
    .src_valid_i(s_axi_bus.arvalid), .src_data_i(ar_in_s), .src_ready_o(s_axi_bus.arready),
    .dst_valid_o(m_axi_bus.arvalid), .dst_data_o(ar_out_s), .dst_ready_i(m_axi_bus.arready),
    .idle_o(ar_idle_s)
  );

  cl_axi_skid_slice #(.WIDTH($bits(b_payload_t)), .MODE(B_MODE)) u_b (
    .clk_i(clock), .rst_i(reset),
    .src_valid_i(m_axi_bus.bvalid), .src_data_i(b_in_s), .src_ready_o(m_axi_bus.bready),
    .dst_valid_o(s_axi_bus.bvalid), .dst_data_o(b_out_s), .dst_ready_i(s_axi_bus.bready),
    .idle_o(b_idle_s)
  );

  cl_axi_skid_slice #(.WIDTH($bits(r_payload_t)), .MODE(R_MODE)) u_r (
    .clk_i(clock), .rst_i(reset),
    .src_valid_i(m_axi_bus.rvalid), .src_data_i(r_in_s), .src_ready_o(m_axi_bus.rready),
    .dst_valid_o(s_axi_bus.rvalid), .dst_data_o(r_out_s), .dst_ready_i(s_axi_bus.rready),
    .idle_o(r_idle_s)
  );

  assign idle = aw_idle_s & w_idle_s & ar_idle_s & b_idle_s & r_idle_s;

endmodule

// File: tb/tb_cl_axi_reg_slice.sv
// Directed and randomized bench for cl_axi_reg_slice with a per-channel ordering scoreboard.
module tb_cl_axi_reg_slice;
  import cl_axi_slice_pkg::*;

  logic clock;
  logic reset;
  logic idle, idle2;

  axi_bus_t s_bus();
  axi_bus_t m_bus();
  axi_bus_t s2();
  axi_bus_t m2();

  cl_axi_reg_slice dut (
    .clock(clock), .reset(reset), .s_axi_bus(s_bus), .m_axi_bus(m_bus), .idle(idle)
  );

  cl_axi_reg_slice #(.AR_MODE(SLICE_BYPASS)) dut_ar0 (
    .clock(clock), .reset(reset), .s_axi_bus(s2), .m_axi_bus(m2), .idle(idle2)
  );

  // channel index: 0 AW, 1 W, 2 AR, 3 B, 4 R
  logic [4:0]  drv_v, drv_r, in_r, out_v, fired;
  logic [63:0] drv_p [5];
  logic [63:0] out_p [5];
  logic [63:0] sb [5][$];
  int          n_checks, n_errors, seq;

  logic        ar2_v, ar2_r;
  logic [31:0] ar2_addr;

  assign s_bus.awvalid = drv_v[0];
  assign {s_bus.awaddr, s_bus.awid, s_bus.awlen, s_bus.awsize} = drv_p[0][46:0];
  assign s_bus.wvalid  = drv_v[1];
  assign {s_bus.wid, s_bus.wdata, s_bus.wstrb, s_bus.wlast} = drv_p[1][40:0];
  assign s_bus.arvalid = drv_v[2];
  assign {s_bus.araddr, s_bus.arid, s_bus.arlen, s_bus.arsize} = drv_p[2][46:0];
  assign m_bus.bvalid  = drv_v[3];
  assign {m_bus.bid, m_bus.bresp} = drv_p[3][5:0];
  assign m_bus.rvalid  = drv_v[4];
  assign {m_bus.rid, m_bus.rdata, m_bus.rresp, m_bus.rlast} = drv_p[4][38:0];
  assign m_bus.awready = drv_r[0];
  assign m_bus.wready  = drv_r[1];
  assign m_bus.arready = drv_r[2];
  assign s_bus.bready  = drv_r[3];
  assign s_bus.rready  = drv_r[4];

  assign in_r  = {m_bus.rready, m_bus.bready, s_bus.arready, s_bus.wready, s_bus.awready};
  assign out_v = {s_bus.rvalid, s_bus.bvalid, m_bus.arvalid, m_bus.wvalid, m_bus.awvalid};
  assign out_p[0] = 64'({m_bus.awaddr, m_bus.awid, m_bus.awlen, m_bus.awsize});
  assign out_p[1] = 64'({m_bus.wid, m_bus.wdata, m_bus.wstrb, m_bus.wlast});
  assign out_p[2] = 64'({m_bus.araddr, m_bus.arid, m_bus.arlen, m_bus.arsize});
  assign out_p[3] = 64'({s_bus.bid, s_bus.bresp});
  assign out_p[4] = 64'({s_bus.rid, s_bus.rdata, s_bus.rresp, s_bus.rlast});

  // second instance: only AR is exercised, everything else is tied off
  assign s2.arvalid = ar2_v;
  assign s2.araddr  = ar2_addr;
  assign s2.arid    = 4'd1;
  assign s2.arlen   = 8'd0;
  assign s2.arsize  = 3'd2;
  assign m2.arready = ar2_r;
  assign {s2.awvalid, s2.awaddr, s2.awid, s2.awlen, s2.awsize} = '0;
  assign {s2.wvalid, s2.wid, s2.wdata, s2.wstrb, s2.wlast, s2.bready, s2.rready} = '0;
  assign {m2.awready, m2.wready, m2.bvalid, m2.bid, m2.bresp} = '0;
  assign {m2.rvalid, m2.rid, m2.rdata, m2.rresp, m2.rlast} = '0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [63:0] chan_mask(input int ch);
    int w;
    case (ch)
      0: w = $bits(aw_payload_t);
      1: w = $bits(w_payload_t);
      2: w = $bits(ar_payload_t);
      3: w = $bits(b_payload_t);
      default: w = $bits(r_payload_t);
    endcase
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [63:0] rp(input int k);
    return 64'({4'd2, 32'hA0 + 32'(k), 2'd0, (k == 2)});
  endfunction

  // scoreboard: every accepted beat must leave once, in order; reset discards buffered beats
  always @(negedge clock) begin
    if (reset) begin
      for (int ch = 0; ch < 5; ch++) sb[ch].delete();
    end else begin
      for (int ch = 0; ch < 5; ch++) begin
        if (out_v[ch] && drv_r[ch]) begin
          chk($sformatf("sb_beat_pending_ch%0d", ch), 64'(sb[ch].size() != 0), 64'd1);
          if (sb[ch].size() != 0) chk($sformatf("sb_order_ch%0d", ch), out_p[ch], sb[ch].pop_front());
        end
        if (drv_v[ch] && in_r[ch]) sb[ch].push_back(drv_p[ch]);
      end
    end
  end

  initial begin
    n_checks = 0; n_errors = 0; seq = 0;
    reset = 1'b1; drv_v = '0; drv_r = '0; fired = '0;
    for (int ch = 0; ch < 5; ch++) drv_p[ch] = '0;
    ar2_v = 1'b0; ar2_r = 1'b0; ar2_addr = '0;

    // reset and release
    repeat (4) tick();
    chk("rst_ready", 64'(in_r), 64'd0);
    chk("rst_valid", 64'(out_v), 64'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_ready", 64'(in_r), 64'h1F);
    chk("post_rst_idle", 64'(idle), 64'd1);

    // single AW beat: one cycle latency, idle returns
    drv_r[0] = 1'b1;
    drv_v[0] = 1'b1;
    drv_p[0] = 64'({32'h1000, 4'd3, 8'd7, 3'd2});
    chk("aw_no_comb_path", 64'(m_bus.awvalid), 64'd0);
    tick();
    drv_v[0] = 1'b0;
    chk("aw_valid", 64'(m_bus.awvalid), 64'd1);
    chk("aw_payload", out_p[0], 64'({32'h1000, 4'd3, 8'd7, 3'd2}));
    chk("aw_busy", 64'(idle), 64'd0);
    tick();
    chk("aw_drained", 64'(m_bus.awvalid), 64'd0);
    chk("aw_idle", 64'(idle), 64'd1);

    // 8-beat W burst at full rate
    drv_r[1] = 1'b1;
    for (int k = 0; k < 9; k++) begin
      drv_v[1] = (k < 8);
      drv_p[1] = 64'({4'd1, 32'(k), 4'hF, (k == 7)});
      if (k > 0) begin
        chk("w_valid", 64'(m_bus.wvalid), 64'd1);
        chk("w_data", 64'(m_bus.wdata), 64'(k - 1));
        chk("w_last", 64'(m_bus.wlast), 64'(k == 8));
      end
      chk("w_src_ready", 64'(s_bus.wready), 64'd1);
      tick();
    end
    chk("w_done", 64'(m_bus.wvalid), 64'd0);

    // R stalled for 5 cycles with 3 beats offered
    drv_r[4] = 1'b0;
    drv_v[4] = 1'b1;
    drv_p[4] = rp(0);
    tick();
    drv_p[4] = rp(1);
    tick();
    drv_p[4] = rp(2);
    chk("r_full_ready", 64'(m_bus.rready), 64'd0);
    for (int c = 0; c < 3; c++) begin
      chk("r_stall_valid", 64'(s_bus.rvalid), 64'd1);
      chk("r_stall_data", out_p[4], rp(0));
      tick();
    end
    drv_r[4] = 1'b1;
    chk("r_rel_beat0", out_p[4], rp(0));
    tick();
    chk("r_rel_beat1", out_p[4], rp(1));
    tick();
    drv_v[4] = 1'b0;
    chk("r_rel_beat2", out_p[4], rp(2));
    tick();
    chk("r_done", 64'(s_bus.rvalid), 64'd0);

    // B slice filled, then reset discards both beats
    drv_r[3] = 1'b0;
    drv_v[3] = 1'b1;
    drv_p[3] = 64'({4'd5, 2'd1});
    tick();
    drv_p[3] = 64'({4'd6, 2'd2});
    tick();
    drv_v[3] = 1'b0;
    chk("b_full_ready", 64'(m_bus.bready), 64'd0);
    chk("b_full_valid", 64'(s_bus.bvalid), 64'd1);
    reset = 1'b1;
    tick();
    tick();
    chk("b_rst_valid", 64'(s_bus.bvalid), 64'd0);
    reset = 1'b0;
    drv_r[3] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("b_no_beat_after_rst", 64'(s_bus.bvalid), 64'd0);
    end
    chk("b_rst_idle", 64'(idle), 64'd1);

    // AR pass-through build: same-cycle propagation both ways
    ar2_addr = 32'h2000;
    ar2_v = 1'b1;
    #1;
    chk("ar0_valid", 64'(m2.arvalid), 64'd1);
    chk("ar0_addr", 64'(m2.araddr), 64'h2000);
    chk("ar0_ready_low", 64'(s2.arready), 64'd0);
    ar2_r = 1'b1;
    #1;
    chk("ar0_ready_high", 64'(s2.arready), 64'd1);
    chk("ar0_idle", 64'(idle2), 64'd1);
    ar2_v = 1'b0;
    #1;
    chk("ar0_valid_low", 64'(m2.arvalid), 64'd0);
    tick();

    // random valid/ready on every channel; valid holds until accepted
    fired = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int ch = 0; ch < 5; ch++) begin
        if (!drv_v[ch] || fired[ch]) begin
          drv_v[ch] = 1'($urandom_range(0, 1));
          drv_p[ch] = (({32'($urandom), 32'($urandom)} << 16) | 64'(seq[15:0])) & chan_mask(ch);
          seq++;
        end
        drv_r[ch] = 1'($urandom_range(0, 1));
      end
      @(negedge clock);
      fired = drv_v & in_r;
      tick();
    end
    drv_v = '0;
    drv_r = '1;
    repeat (6) tick();
    for (int ch = 0; ch < 5; ch++) chk($sformatf("sb_drained_ch%0d", ch), 64'(sb[ch].size()), 64'd0);
    chk("final_idle", 64'(idle), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cl_axi_reg_slice.md
CL_AXI_REG_SLICE -- requirements
Module: cl_axi_reg_slice

Interface
REQ-001 Parameter AW_MODE, default 1, AW channel mode: 0 = combinational pass-through, 1 = registered skid slice.
REQ-002 Parameter W_MODE, default 1, W channel mode, encoding as REQ-001.
REQ-003 Parameter B_MODE, default 1, B channel mode, encoding as REQ-001.
REQ-004 Parameter AR_MODE, default 1, AR channel mode, encoding as REQ-001.
REQ-005 Parameter R_MODE, default 1, R channel mode, encoding as REQ-001.
REQ-006 clock  input  1  single clock for all channels.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 s_axi_bus  axi_bus_t.master  -  upstream side; the block receives AW/W/AR from it and returns B/R to it.
REQ-009 m_axi_bus  axi_bus_t.slave  -  downstream side; the block drives AW/W/AR to it and receives B/R from it.
REQ-010 idle  output  1  high when every registered channel holds zero entries.

Function
REQ-011 Forwarded payloads: AW {awaddr, awid, awlen, awsize}, W {wid, wdata, wstrb, wlast}, AR {araddr, arid, arlen, arsize}, B {bid, bresp}, R {rid, rdata, rresp, rlast}.
REQ-012 Mode 0 channel SHALL be a pure wire: valid, payload and ready connected straight through, zero latency, no state.
REQ-013 Mode 1 channel SHALL be a 2-entry skid slice: main register plus skid register, states EMPTY, ONE, FULL.
REQ-014 Mode 1 outputs: dst valid = (state != EMPTY); dst payload = main register; src ready = registered, high iff state != FULL.
REQ-015 Transitions, in_fire = src valid & src ready, out_fire = dst valid & dst ready: EMPTY+in -> ONE (main<=in).
REQ-016 ONE+in, no out -> FULL (skid<=in); ONE+out, no in -> EMPTY; ONE+in+out -> ONE (main<=in).
REQ-017 FULL+out -> ONE (main<=skid); FULL without out -> FULL; in_fire cannot occur in FULL.
REQ-018 Mode 1 latency SHALL be exactly 1 cycle from src acceptance to dst valid when the channel was EMPTY.
REQ-019 Mode 1 sustained throughput SHALL be one beat per cycle with dst ready held high.
REQ-020 Beat order SHALL be preserved per channel; no beat dropped or duplicated.
REQ-021 Dst payload SHALL stay stable while dst valid is high and dst ready is low.
REQ-022 Src ready SHALL not depend combinationally on dst ready in mode 1.
REQ-023 Channels SHALL operate independently; no cross-channel ordering imposed.
REQ-024 idle SHALL be combinational over registered channel states; mode-0 channels contribute 1.

Reset
REQ-025 While reset is high every mode-1 slice SHALL go to EMPTY: dst valid 0, src ready 0.
REQ-026 Src ready SHALL rise in the first cycle after reset deasserts.
REQ-027 idle SHALL be 1 in the first cycle after reset deasserts.
REQ-028 Register contents need no reset; they SHALL never be presented while the channel is EMPTY.
REQ-029 Reset asserted mid-transfer SHALL discard all buffered beats; no beat SHALL be emitted after reset.

Structure
REQ-030 Package cl_axi_slice_pkg SHALL hold the mode constants (SLICE_BYPASS=0, SLICE_REG=1) and packed payload struct typedefs for AW, W, B, AR, R.
REQ-031 One generic sub-module cl_axi_skid_slice, parameters WIDTH and MODE, SHALL implement REQ-012..022.
REQ-032 The top SHALL instantiate it five times: three forward channels (AW, W, AR) and two reverse channels (B, R).

Verification
REQ-033 Reset 4 cycles, then release -> s_axi_bus awready/wready/arready and m_axi_bus bready/rready = 1 next cycle; idle = 1.
REQ-034 AW beat awaddr=0x1000, awid=3, awlen=7, downstream awready=1 -> m awvalid high exactly 1 cycle later with identical fields; idle returns to 1.
REQ-035 W burst of 8 beats wdata=0..7, wlast on beat 7, downstream wready=1 continuously -> 8 consecutive output beats, same order, wlast only on beat 7.
REQ-036 R channel, downstream rready held low for 5 cycles with 3 beats offered -> 2 buffered, m_axi_bus rready low after 2nd; on release beats appear in order, payload stable while stalled.
REQ-037 Random valid/ready at 50 % on all channels for 10,000 cycles -> scoreboard confirms no loss, duplication or reorder per channel.
REQ-038 AR_MODE=0 build -> arvalid/araddr/arready propagate in the same cycle; reset asserted with B FULL -> bvalid 0 and no B beat after release.
